// File: rtl/mips_pkg.sv
// mips_pkg: opcode, function and REGIMM-rt constants, compare-bit positions and target-select encodings
package mips_pkg;
   localparam logic [5:0] OP_SPECIAL = 6'b000000;
   localparam logic [5:0] OP_REGIMM  = 6'b000001;
   localparam logic [5:0] OP_J       = 6'b000010;
   localparam logic [5:0] OP_JAL     = 6'b000011;
   localparam logic [5:0] OP_BEQ     = 6'b000100;
   localparam logic [5:0] OP_BNE     = 6'b000101;
   localparam logic [5:0] OP_BLEZ    = 6'b000110;
   localparam logic [5:0] OP_BGTZ    = 6'b000111;
   localparam logic [5:0] OP_ADDI    = 6'b001000;
   localparam logic [5:0] OP_ADDIU   = 6'b001001;
   localparam logic [5:0] OP_SLTI    = 6'b001010;
   localparam logic [5:0] OP_SLTIU   = 6'b001011;
   localparam logic [5:0] OP_LB      = 6'b100000;
   localparam logic [5:0] OP_LH      = 6'b100001;
   localparam logic [5:0] OP_LW      = 6'b100011;
   localparam logic [5:0] OP_LBU     = 6'b100100;
   localparam logic [5:0] OP_LHU     = 6'b100101;
   localparam logic [5:0] OP_SB      = 6'b101000;
   localparam logic [5:0] OP_SH      = 6'b101001;
   localparam logic [5:0] OP_SWL     = 6'b101010;
   localparam logic [5:0] OP_SW      = 6'b101011;
   localparam logic [5:0] OP_SWR     = 6'b101110;
   localparam logic [5:0] FN_JR      = 6'b001000;
   localparam logic [5:0] FN_JALR    = 6'b001001;
   localparam logic [4:0] RT_BLTZ    = 5'b00000;
   localparam logic [4:0] RT_BGEZ    = 5'b00001;
   localparam int CMP_GT = 2;
   localparam int CMP_EQ = 1;
   localparam int CMP_LT = 0;
   localparam logic [1:0] SEL_BR = 2'd0;
   localparam logic [1:0] SEL_J  = 2'd1;
   localparam logic [1:0] SEL_JR = 2'd2;
   function automatic logic is_ext_op(input logic [5:0] op);
      return op inside {OP_LW, OP_SW, OP_LB, OP_LBU, OP_LH, OP_LHU, OP_SB, OP_SH,
                        OP_SLTI, OP_SLTIU, OP_ADDI, OP_ADDIU, OP_SWL, OP_SWR};
   endfunction
endpackage

// File: rtl/bht_counters.sv
// bht_counters: saturating-counter branch history table with write-first lookup
// Ports: clk, reset (sync, active-high); f_pc lookup address -> pred_taken;
//        upd_en/upd_pc/upd_taken train the counter indexed by upd_pc at the clock edge.
module bht_counters #(
   parameter int BHT_DEPTH = 64,
   parameter int IDX_LSB   = 2,
   parameter int CTR_W     = 2,
   parameter int CTR_INIT  = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] f_pc,
   output logic        pred_taken,
   input  logic        upd_en,
   input  logic [31:0] upd_pc,
   input  logic        upd_taken
);
   localparam int IDX_W = $clog2(BHT_DEPTH);
   localparam logic [CTR_W-1:0] INIT = CTR_W'(CTR_INIT);
   localparam logic [CTR_W-1:0] MAX  = {CTR_W{1'b1}};
   logic [CTR_W-1:0] ctr_q [BHT_DEPTH];
   logic [IDX_W-1:0] f_idx, u_idx;
   logic [CTR_W-1:0] cur, upd_d;
   // Shifting the whole PC keeps the index a plain modulo-BHT_DEPTH slice; upper bits alias.
   assign f_idx = IDX_W'(f_pc >> IDX_LSB);
   assign u_idx = IDX_W'(upd_pc >> IDX_LSB);
   assign cur   = ctr_q[u_idx];
   assign upd_d = upd_taken ? (cur == MAX ? cur : cur + 1'b1) : (cur == '0 ? cur : cur - 1'b1);
   // Write-first: a lookup hitting the entry being trained this cycle sees the new value.
   assign pred_taken = reset ? INIT[CTR_W-1] :
                       (upd_en && u_idx == f_idx) ? upd_d[CTR_W-1] : ctr_q[f_idx][CTR_W-1];
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < BHT_DEPTH; i++) ctr_q[i] <= INIT;
      end else if (upd_en) begin
         ctr_q[u_idx] <= upd_d;
      end
   end
endmodule

// File: rtl/branch_unit_d.sv
// branch_unit_d: D-stage branch/jump decode and resolution with BHT prediction and mispredict flag
// Ports: clk, reset (sync, active-high); f_pc -> f_pred_taken (BHT lookup);
//        d_valid, d_stall, d_pc, d_ir, d_pred_taken, ab_cmp, a0_cmp describe the D instruction;
//        ext_sel, b_j_jr_sel, pc_sel, is_cond_br are pure decode; mispredict flags a wrong prediction.
// Optional macro BRANCH_STATS_EN adds stat_branches / stat_mispredicts saturating counters.
module branch_unit_d
   import mips_pkg::*;
#(
   parameter int BHT_DEPTH = 64,
   parameter int IDX_LSB   = 2,
   parameter int CTR_W     = 2,
   parameter int CTR_INIT  = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] f_pc,
   output logic        f_pred_taken,
   input  logic        d_valid,
   input  logic        d_stall,
   input  logic [31:0] d_pc,
   input  logic [31:0] d_ir,
   input  logic        d_pred_taken,
   input  logic [2:0]  ab_cmp,
   input  logic [2:0]  a0_cmp,
   output logic        ext_sel,
   output logic [1:0]  b_j_jr_sel,
   output logic        pc_sel,
   output logic        mispredict,
   output logic        is_cond_br
`ifdef BRANCH_STATS_EN
   ,
   output logic [31:0] stat_branches,
   output logic [31:0] stat_mispredicts
`endif
);
   logic [5:0] op, fn;
   logic [4:0] rt;
   logic is_beq, is_bne, is_blez, is_bgtz, is_bltz, is_bgez, is_j, is_jr, taken, train;
   logic unused_bits;
   assign op = d_ir[31:26];
   assign rt = d_ir[20:16];
   assign fn = d_ir[5:0];
   assign unused_bits = ^{d_ir[25:21], d_ir[15:6], ab_cmp[2], ab_cmp[0]};
   assign is_beq  = op == OP_BEQ;
   assign is_bne  = op == OP_BNE;
   assign is_blez = op == OP_BLEZ;
   assign is_bgtz = op == OP_BGTZ;
   assign is_bltz = op == OP_REGIMM && rt == RT_BLTZ;
   assign is_bgez = op == OP_REGIMM && rt == RT_BGEZ;
   assign is_j    = op == OP_J || op == OP_JAL;
   assign is_jr   = op == OP_SPECIAL && (fn == FN_JR || fn == FN_JALR);
   assign is_cond_br = is_beq | is_bne | is_blez | is_bgtz | is_bltz | is_bgez;
   assign taken = (is_beq & ab_cmp[CMP_EQ]) | (is_bne & ~ab_cmp[CMP_EQ]) |
                  (is_blez & (a0_cmp[CMP_LT] | a0_cmp[CMP_EQ])) | (is_bgtz & a0_cmp[CMP_GT]) |
                  (is_bltz & a0_cmp[CMP_LT]) | (is_bgez & (a0_cmp[CMP_GT] | a0_cmp[CMP_EQ]));
   assign ext_sel    = is_ext_op(op);
   assign b_j_jr_sel = is_jr ? SEL_JR : is_j ? SEL_J : SEL_BR;
   assign pc_sel     = is_j | is_jr | taken;
   // A stalled or bubbled instruction neither trains nor flushes; reset discards it too.
   assign train      = ~reset & d_valid & ~d_stall & is_cond_br;
   assign mispredict = train & (taken != d_pred_taken);
   bht_counters #(
      .BHT_DEPTH(BHT_DEPTH), .IDX_LSB(IDX_LSB), .CTR_W(CTR_W), .CTR_INIT(CTR_INIT)
   ) u_bht (
      .clk(clk), .reset(reset), .f_pc(f_pc), .pred_taken(f_pred_taken),
      .upd_en(train), .upd_pc(d_pc), .upd_taken(taken)
   );
`ifdef BRANCH_STATS_EN
   logic [31:0] br_q, mp_q;
   always_ff @(posedge clk) begin
      if (reset) begin
         br_q <= '0;
         mp_q <= '0;
      end else begin
         if (train && ~&br_q) br_q <= br_q + 32'd1;
         if (mispredict && ~&mp_q) mp_q <= mp_q + 32'd1;
      end
   end
   assign stat_branches    = br_q;
   assign stat_mispredicts = mp_q;
`endif
endmodule

// File: tb/tb_branch_unit_d.sv
// tb_branch_unit_d: scoreboard bench for branch_unit_d against a behavioural table model
module tb_branch_unit_d;
   logic clk = 0, reset, d_valid, d_stall, d_pred_taken;
   logic [31:0] f_pc, d_pc, d_ir;
   logic [2:0] ab_cmp, a0_cmp;
   logic f_pred_taken, ext_sel, pc_sel, mispredict, is_cond_br;
   logic [1:0] b_j_jr_sel;
`ifdef BRANCH_STATS_EN
   logic [31:0] stat_branches, stat_mispredicts;
   int m_br = 0, m_mp = 0;
`endif
   always #5 clk = ~clk;
   branch_unit_d dut (
      .clk(clk), .reset(reset), .f_pc(f_pc), .f_pred_taken(f_pred_taken),
      .d_valid(d_valid), .d_stall(d_stall), .d_pc(d_pc), .d_ir(d_ir),
      .d_pred_taken(d_pred_taken), .ab_cmp(ab_cmp), .a0_cmp(a0_cmp),
      .ext_sel(ext_sel), .b_j_jr_sel(b_j_jr_sel), .pc_sel(pc_sel),
      .mispredict(mispredict), .is_cond_br(is_cond_br)
`ifdef BRANCH_STATS_EN
      , .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
`endif
   );
   typedef struct {
      logic ps; logic [1:0] sel; logic ext, mis, cond, fp;
`ifdef BRANCH_STATS_EN
      int br, mp;
`endif
   } exp_t;
   exp_t q[$];
   int ctr[64];
   int checks = 0, errors = 0;
   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask
   // Monitor: outputs are combinational, so every issued cycle presents a result at the next negedge.
   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         chk("pc_sel", int'(pc_sel), int'(e.ps));
         chk("b_j_jr_sel", int'(b_j_jr_sel), int'(e.sel));
         chk("ext_sel", int'(ext_sel), int'(e.ext));
         chk("mispredict", int'(mispredict), int'(e.mis));
         chk("is_cond_br", int'(is_cond_br), int'(e.cond));
         chk("f_pred_taken", int'(f_pred_taken), int'(e.fp));
`ifdef BRANCH_STATS_EN
         chk("stat_branches", int'(stat_branches), e.br);
         chk("stat_mispredicts", int'(stat_mispredicts), e.mp);
`endif
      end
   end
   // Drive one D/F cycle and push the reference expectation computed from the instruction rules.
   task automatic step(input logic r, input logic [31:0] fp, input logic v, input logic s,
                       input logic [31:0] dp, input logic [31:0] ir, input logic pr,
                       input logic [2:0] ab, input logic [2:0] a0);
      exp_t e;
      int op, rt, fn, di, c;
      logic cond, tk, jmp, trn;
      @(posedge clk); #1;
      reset = r; f_pc = fp; d_valid = v; d_stall = s; d_pc = dp; d_ir = ir;
      d_pred_taken = pr; ab_cmp = ab; a0_cmp = a0;
      op = int'(ir >> 26); rt = int'((ir >> 16) & 32'h1F); fn = int'(ir & 32'h3F);
      cond = 0; tk = 0; jmp = 0; e.sel = 0;
      case (op)
         4: begin cond = 1; tk = ab[1]; end
         5: begin cond = 1; tk = !ab[1]; end
         6: begin cond = 1; tk = a0[0] | a0[1]; end
         7: begin cond = 1; tk = a0[2]; end
         1: if (rt == 0) begin cond = 1; tk = a0[0]; end
            else if (rt == 1) begin cond = 1; tk = a0[2] | a0[1]; end
         2, 3: begin jmp = 1; e.sel = 1; end
         0: if (fn == 8 || fn == 9) begin jmp = 1; e.sel = 2; end
         default: ;
      endcase
      e.cond = cond;
      e.ps = jmp | (cond & tk);
      e.ext = op inside {35, 43, 32, 36, 33, 37, 40, 41, 10, 11, 8, 9, 42, 46};
      trn = !r && v && !s && cond;
      e.mis = trn && (tk != pr);
      if (r) begin
         foreach (ctr[i]) ctr[i] = 1;
         e.fp = 0;
      end else begin
         di = int'((dp >> 2) & 32'h3F);
         if (trn) begin
            c = ctr[di];
            ctr[di] = tk ? (c < 3 ? c + 1 : 3) : (c > 0 ? c - 1 : 0);
         end
         e.fp = ctr[int'((fp >> 2) & 32'h3F)] >= 2;
      end
`ifdef BRANCH_STATS_EN
      // Stats are registered: the values seen this cycle reflect earlier cycles only.
      e.br = m_br; e.mp = m_mp;
      if (r) begin m_br = 0; m_mp = 0; end
      else begin m_br += int'(trn); m_mp += int'(e.mis); end
`endif
      q.push_back(e);
   endtask
   localparam logic [31:0] BEQ  = {6'h04, 26'h0};
   localparam logic [31:0] BLTZ = {6'h01, 5'd3, 5'd0, 16'h0};
   localparam logic [31:0] JR   = {6'h00, 5'd31, 15'h0, 6'h08};
   localparam logic [31:0] JAL  = {6'h03, 26'h12345};
   localparam logic [31:0] LUI  = {6'h0F, 26'h0ABCD};
   initial begin
      logic [31:0] r, ir, pcs, pcf;
      int k, w;
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 32'h3000, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 64; i++) step(0, i * 4, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 1, 0, 32'h3008, BEQ, 0, 3'b010, 0);
      step(0, 32'h3008, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) step(0, 32'h3010, 1, 0, 32'h3010, BEQ, 0, 3'b010, 0);
      step(0, 32'h3010, 1, 0, 32'h3010, BEQ, 1, 3'b000, 0);
      step(0, 32'h3010, 0, 0, 0, 0, 0, 0, 0);
      step(0, 32'h14, 1, 0, 32'h14, BEQ, 0, 3'b010, 0);
      step(0, 32'h40, 1, 1, 32'h40, BLTZ, 0, 0, 3'b001);
      step(0, 32'h40, 1, 1, 32'h40, BLTZ, 0, 0, 3'b001);
      step(0, 32'h40, 1, 0, 32'h40, BLTZ, 0, 0, 3'b001);
      step(0, 32'h40, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 1, 0, 0, JR, 0, 0, 0);
      step(0, 0, 1, 0, 0, JAL, 0, 0, 0);
      step(0, 0, 1, 0, 0, LUI, 0, 0, 0);
      step(1, 32'h3008, 1, 0, 32'h3008, BEQ, 0, 3'b010, 0);
      step(0, 32'h3008, 0, 0, 0, 0, 0, 0, 0);
      for (int n = 0; n < 600; n++) begin
         r = $urandom; pcs = $urandom; pcf = $urandom;
         k = $urandom_range(0, 9);
         w = $urandom_range(0, 7);
         case (k)
            0: ir = {6'h04, r[25:0]};
            1: ir = {6'h05, r[25:0]};
            2: ir = {6'h06, r[25:0]};
            3: ir = {6'h07, r[25:0]};
            4: ir = {6'h01, r[25:21], 4'b0000, r[0], r[15:0]};
            5: ir = {5'b00001, r[0], r[25:0]};
            6: ir = {6'h00, r[25:6], 5'b00100, r[0]};
            7: ir = {r[31:26], r[25:0]};
            8: ir = {6'h01, r[25:21], 5'd0, r[15:0]};
            default: ir = {6'h04, r[25:0]};
         endcase
         step($urandom_range(0, 59) == 0, (pcf & 32'hFFFF_FF00) | 32'(w * 4),
              $urandom_range(0, 5) != 0, $urandom_range(0, 4) == 0,
              (pcs & 32'hFFFF_FF00) | 32'($urandom_range(0, 7) * 4), ir,
              1'($urandom), 3'($urandom), 3'($urandom));
      end
      for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
      @(negedge clk); #1;
      chk("queue_drained", q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
